hack_pc_jump: RTL and testbench

Hack-style program counter with an integrated jump-condition unit. It consumes the ALU status flags (zr, ng) and the jump field of a C-instruction. It selects the next instruction address: jump target, increment, or restart. It sits downstream of the combinational gate/ALU stage and upstream of instruction ROM addressing. It also flags the canonical Hack halt idiom (jump-to-self) and counts taken jumps for debug.

---
 rtl/hack_pc_jump_if.sv | 37 +++
 rtl/hack_pc_jump.sv | 99 +++++++++
 tb/tb_hack_pc_jump.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hack_pc_jump_if.sv
`default_nettype none
// ============================================================================
//  Module      : hack_pc_jump_if
//  Description : Control/status bundle between the ALU/decode stage and the
//                Hack program counter. The master drives the instruction
//                fields and ALU flags. The slave (the PC unit) returns the
//                registered address and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hack_pc_jump_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             soft_reset;
    logic             instr_c;
    logic [2:0]       jmp;
    logic             zr;
    logic             ng;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] pc;
    logic             taken;
    logic             halted;
    logic [7:0]       jump_count;

    // Upstream side: decode/ALU stage, or a test driver.
    modport master (
        output en, soft_reset, instr_c, jmp, zr, ng, a_in,
        input  pc, taken, halted, jump_count
    );

    // PC unit side.
    modport slave (
        input  en, soft_reset, instr_c, jmp, zr, ng, a_in,
        output pc, taken, halted, jump_count
    );
endinterface
`default_nettype wire

// File: rtl/hack_pc_jump.sv
`default_nettype none
// ============================================================================
//  Module      : hack_pc_jump
//  Description : Hack-style program counter with an integrated jump-condition
//                unit. It selects between the jump target, an increment and
//                a restart. It flags the jump-to-self halt idiom and keeps a
//                saturating count of taken jumps. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_pc_jump #(
    parameter int WIDTH       = 16,
    parameter bit HALT_DETECT = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hack_pc_jump_if.slave      bus
);
    localparam logic [WIDTH-1:0] c_pc_zero  = '0;
    localparam logic [WIDTH-1:0] c_pc_one   = WIDTH'(1);
    localparam logic [7:0]       c_cnt_max  = 8'hFF;
    localparam logic [7:0]       c_cnt_zero = 8'h00;
    localparam logic [7:0]       c_cnt_one  = 8'h01;

    logic [WIDTH-1:0] r_pc;
    logic             r_taken;
    logic [7:0]       r_jump_count;

    logic             w_cond;
    logic             w_take;
    logic             w_self_jump;

    // Jump-field decode: j1 selects "negative", j2 selects "zero" and
    // j3 selects "positive". The illegal zr=ng=1 case is not filtered.
    assign w_cond      = (bus.jmp[2] & bus.ng)
                       | (bus.jmp[1] & bus.zr)
                       | (bus.jmp[0] & ~bus.ng & ~bus.zr);
    assign w_take      = bus.instr_c & w_cond & bus.en;
    assign w_self_jump = w_take & (bus.a_in == r_pc);

    // Next-address select. soft_reset outranks the stall, and the stall
    // outranks a jump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= c_pc_zero;
            r_taken <= 1'b0;
        end else if (bus.soft_reset) begin
            r_pc    <= c_pc_zero;
            r_taken <= 1'b0;
        end else if (!bus.en) begin
            r_taken <= 1'b0;
        end else if (w_take) begin
            r_pc    <= bus.a_in;
            r_taken <= 1'b1;
        end else begin
            r_pc    <= r_pc + c_pc_one;
            r_taken <= 1'b0;
        end
    end

    // Debug counter of taken jumps. It saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jump_count <= c_cnt_zero;
        end else if (bus.soft_reset) begin
            r_jump_count <= c_cnt_zero;
        end else if (w_take && (r_jump_count != c_cnt_max)) begin
            r_jump_count <= r_jump_count + c_cnt_one;
        end
    end

    generate
        if (HALT_DETECT) begin : g_halt_detect
            logic r_halted;

            // Sticky flag for a jump to the current address. The pc keeps
            // following the normal rules, so a self-loop holds pc constant.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_halted <= 1'b0;
                end else if (bus.soft_reset) begin
                    r_halted <= 1'b0;
                end else if (w_self_jump) begin
                    r_halted <= 1'b1;
                end
            end

            assign bus.halted = r_halted;
        end else begin : g_halt_off
            logic w_unused_self;
            assign w_unused_self = w_self_jump;
            assign bus.halted    = 1'b0;
        end
    endgenerate

    assign bus.pc         = r_pc;
    assign bus.taken      = r_taken;
    assign bus.jump_count = r_jump_count;
endmodule
`default_nettype wire

// File: tb/tb_hack_pc_jump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hack_pc_jump
//  Description : Self-checking bench for hack_pc_jump. It runs one instance
//                with halt detection and one without, both on the same
//                stimulus, and checks them against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_pc_jump;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        en = 1'b1, soft_reset = 1'b0, instr_c = 1'b0;
    logic [2:0]  jmp = 3'b000;
    logic        zr = 1'b0, ng = 1'b0;
    logic [15:0] a_in = 16'h0000;

    hack_pc_jump_if #(.WIDTH(16)) bus0 ();
    hack_pc_jump_if #(.WIDTH(16)) bus1 ();

    assign bus0.en = en;  assign bus0.soft_reset = soft_reset;
    assign bus0.instr_c = instr_c;  assign bus0.jmp = jmp;
    assign bus0.zr = zr;  assign bus0.ng = ng;  assign bus0.a_in = a_in;
    assign bus1.en = en;  assign bus1.soft_reset = soft_reset;
    assign bus1.instr_c = instr_c;  assign bus1.jmp = jmp;
    assign bus1.zr = zr;  assign bus1.ng = ng;  assign bus1.a_in = a_in;

    hack_pc_jump #(.WIDTH(16), .HALT_DETECT(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus0));
    hack_pc_jump #(.WIDTH(16), .HALT_DETECT(1'b0)) u_dut_nohalt (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [15:0] m_pc = 16'h0;
    logic        m_taken = 1'b0;
    logic        m_halt = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pc",         32'(bus0.pc),         32'(m_pc));
        chk("taken",      32'(bus0.taken),      32'(m_taken));
        chk("halted",     32'(bus0.halted),     32'(m_halt));
        chk("jump_count", 32'(bus0.jump_count), 32'(m_cnt));
        chk("nohalt_pc",  32'(bus1.pc),         32'(m_pc));
        chk("nohalt_halted", 32'(bus1.halted),  32'd0);
        chk("nohalt_count", 32'(bus1.jump_count), 32'(m_cnt));
    endtask

    // One clock edge. The model decides from the current inputs in terms of
    // the ALU result: it is less than, equal to or greater than zero.
    task automatic tick();
        logic lt, eq, gt, cond, take;
        lt   = ng;
        eq   = zr;
        gt   = !ng && !zr;
        cond = (jmp[2] && lt) || (jmp[1] && eq) || (jmp[0] && gt);
        take = instr_c && cond && en;
        @(posedge clk);
        if (soft_reset) begin
            m_pc = 16'h0; m_taken = 1'b0; m_halt = 1'b0; m_cnt = 0;
        end else if (!en) begin
            m_taken = 1'b0;
        end else if (take) begin
            if (a_in == m_pc) m_halt = 1'b1;
            m_pc = a_in; m_taken = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_pc = 16'((32'(m_pc) + 1) % 65536);
            m_taken = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic e, input logic sr, input logic ic, input logic [2:0] j,
                         input logic z, input logic n, input logic [15:0] a);
        en = e; soft_reset = sr; instr_c = ic; jmp = j; zr = z; ng = n; a_in = a;
    endtask

    task automatic jump_to(input logic [15:0] addr);
        drive(1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, addr);
        tick();
    endtask

    typedef struct {
        logic [2:0] jmp;
        logic       zr;
        logic       ng;
        logic       exp_jump;
    } vec_t;

    vec_t vt[21];

    initial begin
        int n_exp;
        logic [2:0] jv;

        // Table: the flags select which jump bit matters. Zero selects j2,
        // negative selects j1, positive (neither flag) selects j3.
        for (int i = 0; i < 21; i++) begin
            jv = 3'(i / 3);
            vt[i].jmp = jv;
            case (i % 3)
                0: begin vt[i].zr = 1'b0; vt[i].ng = 1'b0; vt[i].exp_jump = jv[0]; end
                1: begin vt[i].zr = 1'b1; vt[i].ng = 1'b0; vt[i].exp_jump = jv[1]; end
                default: begin vt[i].zr = 1'b0; vt[i].ng = 1'b1; vt[i].exp_jump = jv[2]; end
            endcase
        end

        // Reset state while rst is held
        #12;
        check_all();
        chk("reset_pc", 32'(bus0.pc), 32'h0);
        rst = 1'b0;

        // Async reset mid-run
        jump_to(16'h0042);
        chk("pre_rst_pc", 32'(bus0.pc), 32'h0042);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0);
        #1 rst = 1'b1;
        #1;
        m_pc = 16'h0; m_taken = 1'b0; m_halt = 1'b0; m_cnt = 0;
        check_all();
        #1 rst = 1'b0;
        tick();
        chk("post_rst_pc", 32'(bus0.pc), 32'h1);

        // Jump-condition sweep from pc=0x0010
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0);
        tick();
        n_exp = 0;
        for (int i = 0; i < 21; i++) begin
            jump_to(16'h0010);
            drive(1'b1, 1'b0, 1'b1, vt[i].jmp, vt[i].zr, vt[i].ng, 16'h0100);
            tick();
            chk($sformatf("sweep_pc[%0d]", i), 32'(bus0.pc), vt[i].exp_jump ? 32'h0100 : 32'h0011);
            chk($sformatf("sweep_taken[%0d]", i), 32'(bus0.taken), 32'(vt[i].exp_jump));
            if (vt[i].exp_jump) n_exp++;
        end
        chk("sweep_count", 32'(bus0.jump_count), 32'(21 + n_exp));

        // Wrap and stall
        jump_to(16'hFFFF);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234);
        tick();
        chk("wrap_pc", 32'(bus0.pc), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h1234);
            tick();
            chk("stall_pc", 32'(bus0.pc), 32'h0);
        end

        // Halt idiom
        jump_to(16'h0020);
        jump_to(16'h0020);
        chk("halt_flag", 32'(bus0.halted), 32'h1);
        chk("halt_taken", 32'(bus0.taken), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0020);
        tick();
        chk("halt_pc_inc", 32'(bus0.pc), 32'h0021);
        chk("halt_sticky", 32'(bus0.halted), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0);
        tick();
        chk("halt_clear", 32'(bus0.halted), 32'h0);

        // Saturation
        for (int i = 0; i < 300; i++) jump_to((i % 2 == 0) ? 16'h0001 : 16'h0002);
        chk("sat_count", 32'(bus0.jump_count), 32'd255);

        // Priority: soft_reset beats stall and a self-jump
        jump_to(16'h0055);
        drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0055);
        tick();
        chk("prio_pc", 32'(bus0.pc), 32'h0);
        chk("prio_count", 32'(bus0.jump_count), 32'h0);
        jump_to(16'h0000);
        chk("nohalt_selfjump", 32'(bus1.halted), 32'h0);
        chk("halt_selfjump", 32'(bus0.halted), 32'h1);

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            soft_reset = ($urandom_range(0, 39) == 0);
            instr_c    = $urandom_range(0, 1) == 1;
            jmp        = 3'($urandom_range(0, 7));
            zr         = ($urandom_range(0, 2) == 0);
            ng         = ($urandom_range(0, 2) == 0);
            a_in       = ($urandom_range(0, 5) == 0) ? m_pc : 16'($urandom_range(0, 65535));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
